// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the calculator ALU: datapath width, opcode
// encodings and the 2-bit error status encodings.
package alu_pkg;

  localparam int WIDTH = 32;

  // Operation select encodings
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MOD   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_SHL   = 4'b1010;
  localparam logic [3:0] OP_SHR   = 4'b1011;
  localparam logic [3:0] OP_CLEAR = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;

  // Error status encodings
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/alu_comb.sv
// alu_comb
// Purely combinational operation decode and compute for the ALU.
// Ports:
//   p, q         - unsigned operands
//   op_code      - operation select
//   next_result  - value to load into the result register
//   next_error   - value to load into the error register
//   hold         - when high the result register keeps its current value
module alu_comb #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [3:0]       op_code,
  output logic [WIDTH-1:0] next_result,
  output logic [1:0]       next_error,
  output logic             hold
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [SHW-1:0]       shamt;
  logic                 q_zero;

  // Widened add gives the carry-out in the top bit; the full-width
  // product exposes the upper half used for multiply overflow.
  assign sum    = {1'b0, p} + {1'b0, q};
  assign prod   = {{WIDTH{1'b0}}, p} * {{WIDTH{1'b0}}, q};
  assign shamt  = q[SHW-1:0];
  assign q_zero = (q == '0);

  always_comb begin
    next_result = '0;
    next_error  = ERR_NONE;
    hold        = 1'b0;
    case (op_code)
      OP_NOP: begin
        hold = 1'b1;
      end
      OP_ADD: begin
        next_result = sum[WIDTH-1:0];
        next_error  = sum[WIDTH] ? ERR_OVF : ERR_NONE;
      end
      OP_SUB: begin
        next_result = p - q;
        next_error  = (q > p) ? ERR_OVF : ERR_NONE;
      end
      OP_MUL: begin
        next_result = prod[WIDTH-1:0];
        next_error  = (prod[2*WIDTH-1:WIDTH] != '0) ? ERR_OVF : ERR_NONE;
      end
      OP_DIV: begin
        // A zero divisor leaves the previous result in place
        if (q_zero) begin
          hold       = 1'b1;
          next_error = ERR_DIV0;
        end else begin
          next_result = p / q;
        end
      end
      OP_MOD: begin
        if (q_zero) begin
          hold       = 1'b1;
          next_error = ERR_DIV0;
        end else begin
          next_result = p % q;
        end
      end
      OP_AND:   next_result = p & q;
      OP_OR:    next_result = p | q;
      OP_XOR:   next_result = p ^ q;
      OP_NOT:   next_result = ~p;
      OP_SHL:   next_result = p << shamt;
      OP_SHR:   next_result = p >> shamt;
      OP_CLEAR: next_result = '0;
      OP_LOAD:  next_result = p;
      default: begin
        hold       = 1'b1;
        next_error = ERR_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu
// 32-bit unsigned ALU with registered result and error status.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset, clears both registers
//   inputP     - operand P
//   inputQ     - operand Q
//   opCode     - operation select
//   outALU     - registered result
//   errorCode  - registered status (00 ok, 01 ovf, 10 div0, 11 illegal)
module alu #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inputP,
  input  logic [WIDTH-1:0] inputQ,
  input  logic [3:0]       opCode,
  output logic [WIDTH-1:0] outALU,
  output logic [1:0]       errorCode
);
  import alu_pkg::*;

  logic [WIDTH-1:0] next_result;
  logic [1:0]       next_error;
  logic             hold;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .p           (inputP),
    .q           (inputQ),
    .op_code     (opCode),
    .next_result (next_result),
    .next_error  (next_error),
    .hold        (hold)
  );

  // Error status is never sticky; it is rewritten every cycle, while the
  // result is only replaced when the operation does not ask to hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outALU    <= '0;
      errorCode <= ERR_NONE;
    end else begin
      if (!hold) begin
        outALU <= next_result;
      end
      errorCode <= next_error;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Scoreboard bench for alu: stimulus pushes hand-computed expectations,
// a monitor process pops and compares one cycle later (or immediately
// for asynchronous reset checks).
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] inputP;
  logic [31:0] inputQ;
  logic [3:0]  opCode;
  logic [31:0] outALU;
  logic [1:0]  errorCode;

  typedef struct {
    logic [31:0] result;
    logic [1:0]  error;
    string       name;
  } exp_t;

  exp_t expQ[$];

  logic issue;
  int   immPending;
  event immEv;

  int testsRun;
  int testsFailed;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inputP    (inputP),
    .inputQ    (inputQ),
    .opCode    (opCode),
    .outALU    (outALU),
    .errorCode (errorCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation at the falling edge and record what it must produce
  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] q,
                               input logic [3:0] op, input logic [31:0] expR,
                               input logic [1:0] expE, input string name);
    exp_t e;
    @(negedge clk);
    inputP = p;
    inputQ = q;
    opCode = op;
    e.result = expR;
    e.error  = expE;
    e.name   = name;
    expQ.push_back(e);
    issue = 1'b1;
  endtask

  // Expect the outputs to match right now, without waiting for a clock
  task automatic expectNow(input logic [31:0] expR, input logic [1:0] expE,
                           input string name);
    exp_t e;
    e.result = expR;
    e.error  = expE;
    e.name   = name;
    expQ.push_back(e);
    immPending = immPending + 1;
    -> immEv;
  endtask

  task automatic checkOutput();
    exp_t e;
    testsRun = testsRun + 1;
    if (expQ.size() == 0) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL unexpected_output: got R=%h E=%b, no expectation queued",
               outALU, errorCode);
    end else begin
      e = expQ.pop_front();
      if (outALU !== e.result || errorCode !== e.error) begin
        testsFailed = testsFailed + 1;
        $display("[TB] FAIL %s: got R=%h E=%b, expected R=%h E=%b",
                 e.name, outALU, errorCode, e.result, e.error);
      end
    end
  endtask

  // Monitor: compares after every edge that captured an issued operation,
  // and on demand for asynchronous checks
  initial begin : monitor
    int immSeen;
    bit edgeIssue;
    immSeen = 0;
    forever begin
      @(posedge clk or immEv);
      edgeIssue = (clk === 1'b1) && (issue === 1'b1) && (rst_n === 1'b1)
                  && (immPending == immSeen);
      if (immPending != immSeen) begin
        immSeen = immSeen + 1;
        checkOutput();
      end else if (edgeIssue) begin
        #1;
        checkOutput();
      end
    end
  end

  initial begin : stimulus
    testsRun    = 0;
    testsFailed = 0;
    immPending  = 0;
    issue       = 1'b0;
    inputP      = 32'h1234_5678;
    inputQ      = 32'h0000_0001;
    opCode      = 4'b1101;
    rst_n       = 1'b0;
    #1;
    expectNow(32'd0, 2'b00, "reset_async");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd77, 32'd3, 4'b1100, 32'd0, 2'b00, "clear");
    applyStimulus(32'd3000, 32'd20617524, 4'b0011, 32'd1723029856, 2'b01, "mul_ovf");
    applyStimulus(32'd6, 32'd7, 4'b0011, 32'd42, 2'b00, "mul_small");
    applyStimulus(32'hFFFF_FFFF, 32'd1, 4'b0001, 32'd0, 2'b01, "add_carry");
    applyStimulus(32'd5, 32'd7, 4'b0010, 32'hFFFF_FFFE, 2'b01, "sub_borrow");
    applyStimulus(32'd7, 32'd5, 4'b0010, 32'd2, 2'b00, "sub_ok");
    applyStimulus(32'd99, 32'd0, 4'b1101, 32'd99, 2'b00, "load");
    applyStimulus(32'd50, 32'd0, 4'b0100, 32'd99, 2'b10, "div_zero");
    applyStimulus(32'd50, 32'd0, 4'b0101, 32'd99, 2'b10, "mod_zero");
    applyStimulus(32'd17, 32'd5, 4'b0101, 32'd2, 2'b00, "mod");
    applyStimulus(32'd100, 32'd7, 4'b0100, 32'd14, 2'b00, "div");
    applyStimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0110, 32'h0000_0000, 2'b00, "and");
    applyStimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0111, 32'hFFFF_FFFF, 2'b00, "or");
    applyStimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1000, 32'hFFFF_FFFF, 2'b00, "xor");
    applyStimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1001, 32'h0F0F_0F0F, 2'b00, "not");
    applyStimulus(32'hF0F0_F0F0, 32'h0000_0024, 4'b1010, 32'h0F0F_0F00, 2'b00, "shl_masked");
    applyStimulus(32'hF0F0_F0F0, 32'h0000_0004, 4'b1011, 32'h0F0F_0F0F, 2'b00, "shr");
    applyStimulus(32'd1, 32'd2, 4'b0000, 32'h0F0F_0F0F, 2'b00, "nop_hold");
    applyStimulus(32'h0001_0000, 32'h0001_0000, 4'b0011, 32'd0, 2'b01, "mul_pow32");
    applyStimulus(32'd6, 32'd7, 4'b0011, 32'd42, 2'b00, "mul_42");
    applyStimulus(32'd1, 32'd1, 4'b1110, 32'd42, 2'b11, "illegal_e");
    applyStimulus(32'd1, 32'd1, 4'b1111, 32'd42, 2'b11, "illegal_f");
    applyStimulus(32'd1, 32'd1, 4'b0000, 32'd42, 2'b00, "err_not_sticky");
    applyStimulus(32'd8, 32'd9, 4'b1101, 32'd8, 2'b00, "load_before_rst");

    @(negedge clk);
    issue = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expectNow(32'd0, 2'b00, "reset_midcycle");

    // Reset held across an edge with a live opcode must keep outputs clear
    @(negedge clk);
    inputP = 32'd5;
    opCode = 4'b1101;
    @(posedge clk);
    #2;
    expectNow(32'd0, 2'b00, "reset_wins");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd5, 32'd0, 4'b1101, 32'd5, 2'b00, "load_after_rst");
    @(negedge clk);
    issue = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
